// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - packet round-robin scheduler feeding one uart_tx serializer
// Optional source-ID header byte per packet, send_trig/tx_bsy pacing, abort on stalled requester.
module uart_tx_sched #(
  parameter int         NUM_REQ     = 3,
  parameter bit         HDR_EN      = 1'b1,
  parameter logic [7:0] HDR_BASE    = 8'hA0,
  parameter int         GAP_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       send_trig,
  output logic [7:0]                 send_data,
  input  logic                       tx_bsy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       sched_busy,
  output logic                       abort_pulse
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(GAP_TIMEOUT);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TIMEOUT - 1);
  localparam logic [GW-1:0] PTR_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    TRIG,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] gap_cnt;
  logic          last_flag;

  logic          any_req;
  logic [GW-1:0] rr_pick;
  logic          gnt_valid;
  logic          gnt_last;
  logic [7:0]    gnt_data;
  logic          xfer;

  // Rotating priority: first valid requester after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    rr_pick = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_req && idx == i && req_valid[i]) begin
          any_req = 1'b1;
          rr_pick = GW'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == GW'(i)) begin
        gnt_valid = req_valid[i];
        gnt_last  = req_last[i];
        gnt_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state == DATA && grant_id == GW'(i)) req_ready[i] = ~tx_bsy;
    end
  end

  assign xfer = (state == DATA) && gnt_valid && !tx_bsy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= PTR_INIT;
      gap_cnt     <= '0;
      last_flag   <= 1'b0;
      grant_id    <= '0;
      send_trig   <= 1'b0;
      send_data   <= '0;
      sched_busy  <= 1'b0;
      abort_pulse <= 1'b0;
    end else begin
      send_trig   <= 1'b0;
      abort_pulse <= 1'b0;
      case (state)
        IDLE: begin
          gap_cnt <= '0;
          if (any_req) begin
            grant_id   <= rr_pick;
            sched_busy <= 1'b1;
            state      <= HDR_EN ? HDR : DATA;
          end
        end
        HDR: begin
          send_data <= HDR_BASE + 8'(grant_id);
          last_flag <= 1'b0;
          send_trig <= 1'b1;
          state     <= TRIG;
        end
        DATA: begin
          if (xfer) begin
            send_data <= gnt_data;
            last_flag <= gnt_last;
            gap_cnt   <= '0;
            send_trig <= 1'b1;
            state     <= TRIG;
          end else if (gap_cnt == GAP_LAST) begin
            // Stalled requester loses its turn; nothing more goes on the line.
            abort_pulse <= 1'b1;
            rr_ptr      <= grant_id;
            gap_cnt     <= '0;
            sched_busy  <= 1'b0;
            state       <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        TRIG: state <= WAIT_HI;
        WAIT_HI: begin
          if (tx_bsy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_bsy) begin
            if (last_flag) begin
              rr_ptr     <= grant_id;
              sched_busy <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

  localparam int NR    = 3;
  localparam int FRAME = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]   req_valid_a, req_last_a, req_ready_a;
  logic [8*NR-1:0] req_data_a;
  logic            send_trig_a, bsy_a, sched_busy_a, abort_a;
  logic [7:0]      send_data_a;
  logic [1:0]      grant_id_a;

  logic [NR-1:0]   req_valid_b, req_last_b, req_ready_b;
  logic [8*NR-1:0] req_data_b;
  logic            send_trig_b, bsy_b, sched_busy_b, abort_b;
  logic [7:0]      send_data_b;
  logic [1:0]      grant_id_b;

  uart_tx_sched #(.NUM_REQ(NR), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .GAP_TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_data(req_data_a),
    .req_last(req_last_a), .req_ready(req_ready_a), .send_trig(send_trig_a),
    .send_data(send_data_a), .tx_bsy(bsy_a), .grant_id(grant_id_a),
    .sched_busy(sched_busy_a), .abort_pulse(abort_a)
  );

  uart_tx_sched #(.NUM_REQ(NR), .HDR_EN(1'b0), .HDR_BASE(8'hA0), .GAP_TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_data(req_data_b),
    .req_last(req_last_b), .req_ready(req_ready_b), .send_trig(send_trig_b),
    .send_data(send_data_b), .tx_bsy(bsy_b), .grant_id(grant_id_b),
    .sched_busy(sched_busy_b), .abort_pulse(abort_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester byte queues for dut_a: {last, data}; valid while unread entries remain.
  logic [8:0] mem_a [NR][64];
  int         rd_a  [NR];
  int         len_a [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid_a[i] = rd_a[i] < len_a[i];
      {req_last_a[i], req_data_a[8*i +: 8]} = mem_a[i][rd_a[i][5:0]];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NR; i++)
      if (req_valid_a[i] && req_ready_a[i]) rd_a[i] <= rd_a[i] + 1;
  end

  task automatic push_a(input int r, input logic [8:0] v);
    mem_a[r][len_a[r]] = v;
    len_a[r] = len_a[r] + 1;
  endtask

  // uart_tx stand-in: busy for FRAME cycles starting the cycle after send_trig.
  logic [7:0] rx_a [$];
  int         fcnt_a, fcnt_b, viol_trig_a, viol_rdy_a, trigs_b;
  logic       prev_trig_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsy_a       <= 1'b0;
      fcnt_a      <= 0;
      prev_trig_a <= 1'b0;
    end else begin
      prev_trig_a <= send_trig_a;
      if (send_trig_a) begin
        rx_a.push_back(send_data_a);
        bsy_a  <= 1'b1;
        fcnt_a <= FRAME - 1;
        if (bsy_a || prev_trig_a) viol_trig_a <= viol_trig_a + 1;
      end else if (bsy_a) begin
        if (fcnt_a == 0) bsy_a <= 1'b0;
        else fcnt_a <= fcnt_a - 1;
      end
      if (bsy_a && req_ready_a != '0) viol_rdy_a <= viol_rdy_a + 1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsy_b  <= 1'b0;
      fcnt_b <= 0;
    end else if (send_trig_b) begin
      trigs_b <= trigs_b + 1;
      bsy_b   <= 1'b1;
      fcnt_b  <= FRAME - 1;
    end else if (bsy_b) begin
      if (fcnt_b == 0) bsy_b <= 1'b0;
      else fcnt_b <= fcnt_b - 1;
    end
  end

  logic [7:0] exp_q [$];
  int         rx_base = 0;

  task automatic wait_idle_a();
    int n;
    n = 0;
    while ((sched_busy_a || rx_a.size() < rx_base + exp_q.size()) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 3000), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_rx(input string tag);
    int got_n;
    got_n = rx_a.size() - rx_base;
    chk({tag, "_cnt"}, 32'(got_n), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_n; k++)
      chk($sformatf("%s_b%0d", tag, k), 32'(rx_a[rx_base + k]), 32'(exp_q[k]));
    rx_base = rx_a.size();
    exp_q.delete();
  endtask

  initial begin
    int n, h, tgt;
    req_valid_b = '0;
    req_data_b  = '0;
    req_last_b  = '0;
    repeat (3) @(negedge clk);

    chk("rst_ready",  32'(req_ready_a), 32'd0);
    chk("rst_trig",   32'(send_trig_a), 32'd0);
    chk("rst_data",   32'(send_data_a), 32'd0);
    chk("rst_grant",  32'(grant_id_a), 32'd0);
    chk("rst_busy",   32'(sched_busy_a), 32'd0);
    chk("rst_abort",  32'(abort_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin with every requester continuously valid, single-byte packets.
    push_a(0, 9'h110); push_a(1, 9'h111); push_a(2, 9'h112);
    push_a(0, 9'h113); push_a(1, 9'h114); push_a(2, 9'h115);
    exp_q = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12,
              8'hA0, 8'h13, 8'hA1, 8'h14, 8'hA2, 8'h15};
    wait_idle_a();
    chk_rx("rr");

    // Three-byte packet from requester 1, with grant/header latency.
    h = rd_a[1];
    push_a(1, 9'h011); push_a(1, 9'h022); push_a(1, 9'h133);
    @(negedge clk);
    chk("grant_cycle_id",   32'(grant_id_a), 32'd1);
    chk("grant_cycle_busy", 32'(sched_busy_a), 32'd1);
    @(negedge clk);
    chk("hdr_trig_lat", 32'(send_trig_a), 32'd1);
    chk("hdr_byte",     32'(send_data_a), 32'hA1);
    exp_q = '{8'hA1, 8'h11, 8'h22, 8'h33};
    wait_idle_a();
    chk_rx("pkt1");
    chk("pkt1_handshakes", 32'(rd_a[1] - h), 32'd3);
    chk("pkt1_busy_after", 32'(sched_busy_a), 32'd0);

    // Requester 0 stalls mid-packet; requester 1 waits its turn.
    push_a(0, 9'h001);
    push_a(1, 9'h177);
    n = 0;
    while (rx_a.size() < rx_base + 2 && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (bsy_a && n < 500) begin @(negedge clk); n++; end
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (abort_a) break;
    end
    chk("gap_len",         32'(n), 32'd17);
    chk("abort_seen",      32'(abort_a), 32'd1);
    chk("abort_busy",      32'(sched_busy_a), 32'd0);
    push_a(0, 9'h102);
    @(negedge clk);
    chk("abort_width",      32'(abort_a), 32'd0);
    chk("post_abort_grant", 32'(grant_id_a), 32'd1);
    exp_q = '{8'hA0, 8'h01, 8'hA1, 8'h77, 8'hA0, 8'h02};
    wait_idle_a();
    chk_rx("abort");

    // Requester 0 holds valid across busy frames.
    h = rd_a[0];
    push_a(0, 9'h051); push_a(0, 9'h052); push_a(0, 9'h153);
    exp_q = '{8'hA0, 8'h51, 8'h52, 8'h53};
    wait_idle_a();
    chk_rx("hold");
    chk("hold_handshakes", 32'(rd_a[0] - h), 32'd3);

    // Reset after the second byte of a requester 1 packet.
    tgt = rd_a[1] + 2;
    push_a(1, 9'h031); push_a(1, 9'h032); push_a(1, 9'h033); push_a(1, 9'h134);
    n = 0;
    while (rd_a[1] < tgt && n < 500) begin @(negedge clk); n++; end
    chk("mid_pkt_busy", 32'(sched_busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_ready", 32'(req_ready_a), 32'd0);
    chk("mrst_trig",  32'(send_trig_a), 32'd0);
    chk("mrst_data",  32'(send_data_a), 32'd0);
    chk("mrst_grant", 32'(grant_id_a), 32'd0);
    chk("mrst_busy",  32'(sched_busy_a), 32'd0);
    len_a[1] = rd_a[1];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rx_base = rx_a.size();
    @(negedge clk);
    push_a(0, 9'h140); push_a(1, 9'h141);
    exp_q = '{8'hA0, 8'h40, 8'hA1, 8'h41};
    wait_idle_a();
    chk_rx("post_rst");

    // Headerless instance: requester 2 single byte.
    req_valid_b = 3'b100;
    req_data_b  = {8'h5A, 16'h0000};
    req_last_b  = 3'b100;
    n = 0;
    while (!req_ready_b[2] && n < 50) begin @(negedge clk); n++; end
    chk("b_ready",     32'(req_ready_b[2]), 32'd1);
    chk("b_grant",     32'(grant_id_b), 32'd2);
    @(negedge clk);
    req_valid_b = '0;
    chk("b_trig_lat",  32'(send_trig_b), 32'd1);
    chk("b_data",      32'(send_data_b), 32'h5A);
    repeat (30) @(negedge clk);
    chk("b_trig_count", 32'(trigs_b), 32'd1);
    chk("b_busy_after", 32'(sched_busy_b), 32'd0);

    chk("trig_protocol", 32'(viol_trig_a), 32'd0);
    chk("ready_in_busy", 32'(viol_rdy_a), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
